// File: rtl/camera_sensor_emulator.sv
// Camera sensor emulator: replays a frame stored as {B,0,G,R} words in memory as a
// parallel Bayer stream (pclk/href/vsync/data), prefetching through a small FIFO.
module camera_sensor_emulator #(
   parameter int unsigned PCLK_DIV = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_BLANK  = 160,
   parameter int unsigned V_LINES  = 480,
   parameter int unsigned V_LEAD   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        camera_data_trigger,
   input  logic [19:0] frame_base,
   output logic [19:0] ddr_addr,
   output logic        ddr_rd_req,
   input  logic        pause,
   input  logic [31:0] data_read,
   input  logic        data_read_valid,
   output logic        cam_pclk,
   output logic        cam_href,
   output logic        cam_vsync,
   output logic [11:0] cam_data,
   output logic        frame_busy,
   output logic        frame_done,
   output logic        underrun
);

   localparam int unsigned LineWords = H_ACTIVE / 2;
   localparam int unsigned LeadTicks = V_LEAD * (H_ACTIVE + H_BLANK);
   localparam int unsigned DivW      = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;
   localparam int unsigned LineW     = $clog2(V_LINES + 2);
   localparam int unsigned ColW      = $clog2(LineWords + 1);

   typedef enum logic [2:0] {StIdle, StLead, StActive, StBlank, StDone} state_e;

   state_e            state_q;
   logic [DivW-1:0]   div_q;
   logic              trig_prev_q;
   logic              trig_pend_q;
   logic [31:0]       cnt_q;
   logic [LineW-1:0]  line_q;
   logic [15:0]       cur_pair_q;

   logic [23:0]       fifo_mem [4];
   logic [1:0]        rd_ptr_q;
   logic [1:0]        wr_ptr_q;
   logic [2:0]        count_q;
   logic              outst_q;
   logic              stale_q;
   logic [ColW-1:0]   col_q;
   logic [LineW-1:0]  fetch_line_q;

   logic              tick;
   logic              trig_edge;
   logic              fifo_empty;
   logic [23:0]       head_word;
   logic              start;
   logic              line_end;
   logic              enter_active;
   logic              pair_slot;
   logic              pop;
   logic              push;
   logic              flush;
   logic              issue;
   logic [19:0]       next_addr;
   logic [11:0]       even_px;
   logic [11:0]       odd_px;

   // The pad byte of each memory word carries no pixel data.
   logic unused_pad;
   assign unused_pad = ^data_read[23:16];

   // Decode pixel ticks, FSM events, FIFO handshakes and the next read address.
   always_comb begin
      tick         = (div_q == '0);
      trig_edge    = camera_data_trigger & ~trig_prev_q;
      fifo_empty   = (count_q == 3'd0);
      head_word    = fifo_empty ? 24'd0 : fifo_mem[rd_ptr_q];
      start        = tick && (state_q == StIdle) && (trig_pend_q || trig_edge);
      line_end     = tick && (state_q == StActive) && (cnt_q == 32'(H_ACTIVE - 1));
      enter_active = tick && (((state_q == StLead) && (cnt_q == 32'(LeadTicks - 1))) ||
                              ((state_q == StBlank) && (cnt_q == 32'(H_BLANK - 1)) &&
                               (line_q < LineW'(V_LINES))));
      // A new word is consumed whenever the next pixel to show has an even index.
      pair_slot    = enter_active ||
                     (tick && (state_q == StActive) && !line_end && cnt_q[0]);
      pop          = pair_slot && !fifo_empty;
      flush        = start || line_end;
      push         = data_read_valid && outst_q && !stale_q && !flush;
      issue        = !flush && (state_q inside {StLead, StActive, StBlank}) && !pause &&
                     !outst_q && (count_q < 3'd4) && (col_q < ColW'(LineWords)) &&
                     (fetch_line_q < LineW'(V_LINES));
      next_addr    = frame_base + 20'((fetch_line_q >> 1) * LineWords) + 20'(col_q);
      even_px      = {(line_q[0] ? head_word[23:16] : head_word[15:8]), 4'h0};
      odd_px       = {(line_q[0] ? cur_pair_q[15:8] : cur_pair_q[7:0]), 4'h0};
   end

   // Pixel clock divider and trigger edge history.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q       <= '0;
         cam_pclk    <= 1'b0;
         trig_prev_q <= 1'b1;
      end else begin
         div_q       <= (div_q == DivW'(PCLK_DIV - 1)) ? '0 : div_q + DivW'(1);
         cam_pclk    <= (div_q < DivW'(PCLK_DIV / 2));
         trig_prev_q <= camera_data_trigger;
      end
   end

   // Frame timing FSM; all sensor outputs are registered and move only on ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         line_q      <= '0;
         trig_pend_q <= 1'b0;
         cur_pair_q  <= '0;
         cam_href    <= 1'b0;
         cam_vsync   <= 1'b0;
         cam_data    <= '0;
         frame_busy  <= 1'b0;
         frame_done  <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if ((state_q == StIdle) && trig_edge) trig_pend_q <= 1'b1;
         if (pair_slot) cur_pair_q <= head_word[15:0];
         if (pair_slot && fifo_empty) underrun <= 1'b1;
         if (tick) begin
            unique case (state_q)
               StIdle: begin
                  if (start) begin
                     state_q     <= StLead;
                     cnt_q       <= '0;
                     line_q      <= '0;
                     trig_pend_q <= 1'b0;
                     cam_vsync   <= 1'b1;
                     frame_busy  <= 1'b1;
                  end
               end
               StLead: begin
                  if (enter_active) begin
                     state_q  <= StActive;
                     cnt_q    <= '0;
                     cam_href <= 1'b1;
                     cam_data <= even_px;
                  end else begin
                     cnt_q <= cnt_q + 32'd1;
                  end
               end
               StActive: begin
                  if (line_end) begin
                     state_q  <= StBlank;
                     cnt_q    <= '0;
                     line_q   <= line_q + LineW'(1);
                     cam_href <= 1'b0;
                     cam_data <= '0;
                  end else begin
                     cnt_q    <= cnt_q + 32'd1;
                     cam_data <= cnt_q[0] ? even_px : odd_px;
                  end
               end
               StBlank: begin
                  if (cnt_q == 32'(H_BLANK - 1)) begin
                     cnt_q <= '0;
                     if (enter_active) begin
                        state_q  <= StActive;
                        cam_href <= 1'b1;
                        cam_data <= even_px;
                     end else begin
                        state_q    <= StDone;
                        cam_vsync  <= 1'b0;
                        frame_busy <= 1'b0;
                        frame_done <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 32'd1;
                  end
               end
               StDone: state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   // Prefetch FIFO, single outstanding read tracking and fetch addressing.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         outst_q      <= 1'b0;
         stale_q      <= 1'b0;
         col_q        <= '0;
         fetch_line_q <= '0;
         ddr_rd_req   <= 1'b0;
         ddr_addr     <= '0;
      end else begin
         ddr_rd_req <= issue;
         if (issue) begin
            ddr_addr <= next_addr;
            col_q    <= col_q + ColW'(1);
         end
         if (data_read_valid && outst_q) begin
            outst_q <= 1'b0;
            stale_q <= 1'b0;
         end else if (issue) begin
            outst_q <= 1'b1;
         end
         if (flush) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            col_q        <= '0;
            fetch_line_q <= start ? '0 : line_q + LineW'(1);
            // A read still in flight belongs to the old line; drop it on return.
            if (outst_q && !data_read_valid) stale_q <= 1'b1;
         end else begin
            if (push) begin
               fifo_mem[wr_ptr_q] <= {data_read[31:24], data_read[15:0]};
               wr_ptr_q           <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            if (push && !pop) count_q <= count_q + 3'd1;
            else if (pop && !push) count_q <= count_q - 3'd1;
         end
      end
   end

endmodule

// File: doc/camera_sensor_emulator.md
CAMERA_SENSOR_EMULATOR -- requirements
Module: camera_sensor_emulator

Interface
REQ-001 SHALL provide parameter PCLK_DIV, default 4, clk cycles per cam_pclk period (even, >=2).
REQ-002 SHALL provide parameter H_ACTIVE, default 640, sensor pixels per active line.
REQ-003 SHALL provide parameter H_BLANK, default 160, pixel periods of href-low blanking after each line.
REQ-004 SHALL provide parameter V_LINES, default 480, active lines per frame.
REQ-005 SHALL provide parameter V_LEAD, default 2, blank line periods between vsync rise and first href.
REQ-006 SHALL provide ports, clock and reset first:
  clk  in  1  system clock; everything is synchronous to it
  reset  in  1  synchronous, active-high reset
  camera_data_trigger  in  1  active-low exposure trigger; a rising edge starts one frame
  frame_base  in  20  memory word address of stored pixel (0,0)
  ddr_addr  out  20  read address
  ddr_rd_req  out  1  one-cycle read request
  pause  in  1  memory busy; no request is issued while high
  data_read  in  32  read word {B,8'h0,G,R}
  data_read_valid  in  1  data_read valid this cycle
  cam_pclk  out  1  emulated pixel clock
  cam_href  out  1  line active
  cam_vsync  out  1  frame active, high for the whole frame
  cam_data  out  12  Bayer pixel, byte in [11:4], [3:0]=0
  frame_busy  out  1  frame in progress
  frame_done  out  1  one-cycle pulse at frame end
  underrun  out  1  sticky: prefetch FIFO empty when a word was needed

Function
REQ-007 SHALL divide clk by PCLK_DIV: cam_pclk high for the first PCLK_DIV/2 cycles of each period; pixel tick = cycle cam_pclk rises.
REQ-008 cam_href, cam_vsync and cam_data SHALL change only on pixel ticks, so they are stable at the cam_pclk falling edge.
REQ-009 Timing FSM states: IDLE, LEAD, ACTIVE, BLANK, DONE.
REQ-010 IDLE -> LEAD on camera_data_trigger 0->1 (registered previous value); vsync=1 from the next tick; frame_busy=1.
REQ-011 LEAD lasts V_LEAD*(H_ACTIVE+H_BLANK) ticks with href=0, then -> ACTIVE.
REQ-012 ACTIVE: href=1 for exactly H_ACTIVE ticks, then -> BLANK.
REQ-013 BLANK: href=0 for H_BLANK ticks; line counter increments; -> ACTIVE if lines < V_LINES, else -> DONE.
REQ-014 DONE: vsync=0, frame_busy=0, frame_done pulses once, -> IDLE on the next tick.
REQ-015 Trigger edges outside IDLE SHALL be ignored.
REQ-016 Line n (0-based) SHALL use stored row n>>1; each stored word covers two sensor pixels.
REQ-017 Even line: pixel 2k = G (word[15:8]), pixel 2k+1 = R (word[7:0]); odd line: pixel 2k = B (word[31:24]), pixel 2k+1 = G (word[15:8]).
REQ-018 Word pops from the prefetch FIFO SHALL occur on even-pixel ticks only; cam_data SHALL be 0 outside ACTIVE.
REQ-019 Prefetch: 4-entry FIFO, at most one read outstanding; issue ddr_rd_req when (count + outstanding) < 4, pause=0, and fetch column < H_ACTIVE/2.
REQ-020 ddr_addr = frame_base + (n>>1)*(H_ACTIVE/2) + fetch column, 20-bit wrap-around.
REQ-021 Fetch column SHALL reset to 0 and the FIFO SHALL flush at the BLANK->ACTIVE transition's preceding BLANK start; prefetch of the next line proceeds during BLANK and LEAD.
REQ-022 data_read_valid with a full FIFO SHALL not occur by construction; data_read_valid with no read outstanding SHALL be ignored.
REQ-023 Pop from an empty FIFO: cam_data pair = 0, underrun set; underrun cleared only by reset.
REQ-024 Simultaneous push and pop in one cycle SHALL leave count unchanged and preserve order.

Reset
REQ-025 reset SHALL force IDLE; cam_pclk, cam_href, cam_vsync, cam_data, ddr_rd_req, ddr_addr, frame_busy, frame_done, underrun = 0; FIFO empty; outstanding cleared; clk divider = 0.
REQ-026 reset mid-frame SHALL take effect next cycle; a read returning after reset SHALL be discarded.

Verification
REQ-027 Trigger 0->1 with memory returning data 1 cycle after request -> 480 href pulses of 640 ticks, vsync high throughout, frame_done once, underrun=0.
REQ-028 Word 0x11002233 at frame_base -> line 0 pixels 0,1 = 0x220,0x330; line 1 pixels 0,1 = 0x110,0x220.
REQ-029 frame_base=0xFFFF0, line 2 -> first ddr_addr = 0x00130 (wrapped 0xFFFF0+320).
REQ-030 pause held high for a full line -> cam_data 0 for affected pixels, underrun=1, frame timing unchanged.
REQ-031 Second trigger rising edge during ACTIVE -> ignored; exactly one frame_done.
REQ-032 reset asserted in line 100 -> all outputs 0 next cycle; a late data_read_valid does not fill the FIFO.
